// File: rtl/tri_raster_ctrl_if.sv
// Pixel result stream between the raster sequencer (master) and the pixel writer (slave).
// One verdict per transfer; a transfer happens when pix_valid & pix_ready.
interface tri_raster_ctrl_if #(
  parameter int W = 11
);
  logic         pix_valid;
  logic         pix_ready;
  logic [W-1:0] pix_x;
  logic [W-1:0] pix_y;
  logic         pix_in;

  modport master (output pix_valid, pix_x, pix_y, pix_in, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_in, output pix_ready);
endinterface

// File: rtl/tri_raster_ctrl.sv
// Point-in-triangle scan sequencer: one shared edge-function unit, three edges per pixel.
// Optional macro CULL_EN: outside pixels are skipped instead of being presented.
module tri_raster_ctrl #(
  parameter int W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     v1_x,
  input  logic [W-1:0]     v1_y,
  input  logic [W-1:0]     v2_x,
  input  logic [W-1:0]     v2_y,
  input  logic [W-1:0]     v3_x,
  input  logic [W-1:0]     v3_y,
  output logic             busy,
  output logic             done,
  tri_raster_ctrl_if.master pix
);

  typedef enum logic [2:0] {IDLE, SETUP, EV0, EV1, EV2, OUT, DONE} state_t;

  state_t state, next_state;

  logic [W-1:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;
  logic [W-1:0] xmin_q, xmax_q, ymax_q;
  logic [W-1:0] cx_q, cy_q;
  logic [2:0]   neg_q, zero_q;

  logic [W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic [W-1:0] p_x, p_y, a_x, a_y, b_x, b_y;
  logic signed [W:0]     d_ax, d_by, d_bx, d_ay;
  logic signed [2*W+1:0] prod_l, prod_r;
  logic signed [2*W+2:0] e_val;
  logic                  e_neg, e_zero;
  logic                  last_pix, step, inside_q;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign xmin_c = min3(v1x_q, v2x_q, v3x_q);
  assign xmax_c = max3(v1x_q, v2x_q, v3x_q);
  assign ymin_c = min3(v1y_q, v2y_q, v3y_q);
  assign ymax_c = max3(v1y_q, v2y_q, v3y_q);

  // Shared edge unit: SETUP evaluates the signed area E(v3,v1,v2), EVn evaluate edge n at (cx,cy).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    p_x = cx_q;  p_y = cy_q;
    a_x = v1x_q; a_y = v1y_q;
    b_x = v2x_q; b_y = v2y_q;
    unique case (state)
      SETUP:   begin p_x = v3x_q; p_y = v3y_q; end
      EV1:     begin a_x = v2x_q; a_y = v2y_q; b_x = v3x_q; b_y = v3y_q; end
      EV2:     begin a_x = v3x_q; a_y = v3y_q; b_x = v1x_q; b_y = v1y_q; end
      default: ;
    endcase
    d_ax   = $signed({1'b0, a_x}) - $signed({1'b0, p_x});
    d_by   = $signed({1'b0, b_y}) - $signed({1'b0, p_y});
    d_bx   = $signed({1'b0, b_x}) - $signed({1'b0, p_x});
    d_ay   = $signed({1'b0, a_y}) - $signed({1'b0, p_y});
    prod_l = $signed({{(W+1){d_ax[W]}}, d_ax}) * $signed({{(W+1){d_by[W]}}, d_by});
    prod_r = $signed({{(W+1){d_bx[W]}}, d_bx}) * $signed({{(W+1){d_ay[W]}}, d_ay});
    e_val  = $signed({prod_l[2*W+1], prod_l}) - $signed({prod_r[2*W+1], prod_r});
  end

  assign e_neg    = e_val[2*W+2];
  assign e_zero   = (e_val == '0);
  assign last_pix = (cx_q == xmax_q) && (cy_q == ymax_q);
  assign inside_q = (~|neg_q) | (&(neg_q | zero_q));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    step       = 1'b0;
    unique case (state)
      IDLE:  if (start) next_state = SETUP;
      SETUP: next_state = e_zero ? DONE : EV0;
      EV0:   next_state = EV1;
      EV1:   next_state = EV2;
`ifdef CULL_EN
      EV2: begin
        if ((~|{e_neg, neg_q[1:0]}) | (&({e_neg, neg_q[1:0]} | {e_zero, zero_q[1:0]}))) begin
          next_state = OUT;
        end else begin
          step       = 1'b1;
          next_state = last_pix ? DONE : EV0;
        end
      end
`else
      EV2:   next_state = OUT;
`endif
      OUT: begin
        if (pix.pix_ready) begin
          step       = 1'b1;
          next_state = last_pix ? DONE : EV0;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy          = state inside {SETUP, EV0, EV1, EV2, OUT};
    done          = (state == DONE);
    pix.pix_valid = (state == OUT);
    pix.pix_x     = cx_q;
    pix.pix_y     = cy_q;
    pix.pix_in    = (state == OUT) && inside_q;
  end

  // NOTE: vertex and bounding-box registers are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      v1x_q <= v1_x; v1y_q <= v1_y;
      v2x_q <= v2_x; v2y_q <= v2_y;
      v3x_q <= v3_x; v3y_q <= v3_y;
    end
    if (state == SETUP) begin
      xmin_q <= xmin_c;
      xmax_q <= xmax_c;
      ymax_q <= ymax_c;
    end
  end

  // Scan position and per-edge sign pairs; max is tested before incrementing, so no wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q   <= '0;
      cy_q   <= '0;
      neg_q  <= '0;
      zero_q <= '0;
    end else begin
      if (state == SETUP) begin
        cx_q <= xmin_c;
        cy_q <= ymin_c;
      end
      unique case (state)
        EV0:     begin neg_q[0] <= e_neg; zero_q[0] <= e_zero; end
        EV1:     begin neg_q[1] <= e_neg; zero_q[1] <= e_zero; end
        EV2:     begin neg_q[2] <= e_neg; zero_q[2] <= e_zero; end
        default: ;
      endcase
      if (step) begin
        if (cx_q != xmax_q) begin
          cx_q <= cx_q + W'(1);
        end else if (cy_q != ymax_q) begin
          cx_q <= xmin_q;
          cy_q <= cy_q + W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Bench for tri_raster_ctrl: spec vectors from a table, hand-written reset abort,
// and random triangles with random back-pressure against an arithmetic reference.
module tb_tri_raster_ctrl;
  localparam int W = 11;
`ifdef CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, busy, done;
  logic [W-1:0] v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;

  tri_raster_ctrl_if #(.W(W)) pix_if ();

  tri_raster_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y), .v3_x(v3_x), .v3_y(v3_y),
    .busy(busy), .done(done), .pix(pix_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int x; int y; bit in;} pix_t;
  typedef struct {
    int ax, ay, bx, by, cx, cy;
    int mode;
    int bbox_cnt;
    int in_cnt;
    string name;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint edge_fn(int px, int py, int ax, int ay, int bx, int by);
    return longint'(ax - px) * longint'(by - py) - longint'(bx - px) * longint'(ay - py);
  endfunction

  // Reference: plain edge arithmetic over the whole bounding box.
  task automatic build_model(input int v[6], output pix_t q[$], output bit last_in);
    int xmin, xmax, ymin, ymax;
    longint e0, e1, e2;
    bit in;
    q = {};
    last_in = 1'b0;
    xmin = v[0]; xmax = v[0]; ymin = v[1]; ymax = v[1];
    for (int k = 1; k < 3; k++) begin
      if (v[2*k] < xmin) xmin = v[2*k];
      if (v[2*k] > xmax) xmax = v[2*k];
      if (v[2*k+1] < ymin) ymin = v[2*k+1];
      if (v[2*k+1] > ymax) ymax = v[2*k+1];
    end
    if (edge_fn(v[4], v[5], v[0], v[1], v[2], v[3]) == 0) return;
    for (int y = ymin; y <= ymax; y++) begin
      for (int x = xmin; x <= xmax; x++) begin
        e0 = edge_fn(x, y, v[0], v[1], v[2], v[3]);
        e1 = edge_fn(x, y, v[2], v[3], v[4], v[5]);
        e2 = edge_fn(x, y, v[4], v[5], v[0], v[1]);
        in = (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
        if (!CULL || in) q.push_back('{x: x, y: y, in: in});
        last_in = in;
      end
    end
  endtask

  // mode 0: ready always high; 1: ready 1-of-3 cycles; 2: random ready, random start/vertex noise.
  task automatic run_tri(input int v[6], input int mode, input string name,
                         input int exp_cnt, input int exp_in);
    pix_t   q[$];
    bit     last_in, r, stall;
    int     got, nin, last_acc, done_cyc, budget;
    logic [W-1:0] sx, sy;
    logic   sin;
    build_model(v, q, last_in);
    @(negedge clk);
    v1_x = W'(v[0]); v1_y = W'(v[1]); v2_x = W'(v[2]);
    v2_y = W'(v[3]); v3_x = W'(v[4]); v3_y = W'(v[5]);
    start = 1'b1;
    pix_if.pix_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_after_start"}, busy, 1);
    budget   = 12 * 64 + 40;
    got      = 0;
    nin      = 0;
    last_acc = -100;
    done_cyc = -1;
    stall    = 1'b0;
    sx = '0; sy = '0; sin = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 2);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2) begin
        start = 1'($urandom_range(0, 1));
        v1_x = W'($urandom); v2_y = W'($urandom); v3_x = W'($urandom);
      end
      pix_if.pix_ready = r;
      if (stall) begin
        check({name, " hold_valid"}, pix_if.pix_valid, 1);
        check({name, " hold_x"}, pix_if.pix_x, sx);
        check({name, " hold_y"}, pix_if.pix_y, sy);
        check({name, " hold_in"}, pix_if.pix_in, sin);
      end
      if (pix_if.pix_valid) begin
        check({name, " busy_in_out"}, busy, 1);
        if (r) begin
          if (got < q.size()) begin
            check($sformatf("%s pix%0d_x", name, got), pix_if.pix_x, q[got].x);
            check($sformatf("%s pix%0d_y", name, got), pix_if.pix_y, q[got].y);
            check($sformatf("%s pix%0d_in", name, got), pix_if.pix_in, q[got].in);
          end
          got++;
          nin += int'(pix_if.pix_in);
          last_acc = cyc;
        end
        stall = !r;
        sx = pix_if.pix_x; sy = pix_if.pix_y; sin = pix_if.pix_in;
      end else begin
        stall = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    pix_if.pix_ready = 1'b0;
    check({name, " done_seen"}, int'(done_cyc >= 0), 1);
    check({name, " pixel_count"}, got, q.size());
    if (exp_cnt >= 0) check({name, " spec_count"}, got, exp_cnt);
    if (exp_in >= 0)  check({name, " spec_inside"}, nin, exp_in);
    if (done_cyc >= 0) begin
      if (q.size() == 0)          check({name, " done_latency"}, done_cyc, 1);
      else if (last_in || !CULL)  check({name, " done_after_last"}, done_cyc, last_acc + 1);
      check({name, " busy_low_at_done"}, busy, 0);
      @(negedge clk);
      check({name, " done_one_cycle"}, done, 0);
    end
  endtask

  vec_t tbl[6];
  int   v[6];
  int   nvalid;

  initial begin
    tbl[0] = '{0, 0, 4, 0, 0, 4, 0, 25, 15, "ccw"};
    tbl[1] = '{0, 4, 4, 0, 0, 0, 0, 25, 15, "cw"};
    tbl[2] = '{0, 0, 4, 0, 0, 4, 1, 25, 15, "stall"};
    tbl[3] = '{0, 0, 2, 2, 4, 4, 0, 0, 0, "collinear"};
    tbl[4] = '{7, 7, 7, 7, 7, 7, 0, 0, 0, "coincident"};
    tbl[5] = '{2047, 2047, 2040, 2047, 2047, 2040, 0, 64, 36, "corner"};

    rst = 1'b1; start = 1'b0; pix_if.pix_ready = 1'b0;
    v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0; v3_x = '0; v3_y = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pix_valid", pix_if.pix_valid, 0);
    check("reset pix_x", pix_if.pix_x, 0);
    check("reset pix_y", pix_if.pix_y, 0);
    check("reset pix_in", pix_if.pix_in, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v = '{tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].cx, tbl[i].cy};
      run_tri(v, tbl[i].mode, tbl[i].name,
              CULL ? tbl[i].in_cnt : tbl[i].bbox_cnt, tbl[i].in_cnt);
    end

    // Reset during the 10th presented pixel aborts silently; the next scan is complete.
    @(negedge clk);
    v1_x = 0; v1_y = 0; v2_x = 4; v2_y = 0; v3_x = 0; v3_y = 4;
    start = 1'b1;
    pix_if.pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvalid = 0;
    for (int cyc = 0; cyc < 400 && nvalid < 10; cyc++) begin
      if (pix_if.pix_valid) nvalid++;
      if (nvalid == 10) begin
        rst = 1'b1;
        pix_if.pix_ready = 1'b0;
      end
      @(negedge clk);
    end
    check("abort reached_10th_out", nvalid, 10);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort pix_valid", pix_if.pix_valid, 0);
    check("abort pix_x", pix_if.pix_x, 0);
    check("abort pix_y", pix_if.pix_y, 0);
    check("abort pix_in", pix_if.pix_in, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort no_done", done, 0);
    end
    v = '{0, 0, 4, 0, 0, 4};
    run_tri(v, 0, "after_abort", CULL ? 15 : 25, 15);

    for (int i = 0; i < 24; i++) begin
      int bx, by;
      bx = $urandom_range(0, 2047 - 6);
      by = $urandom_range(0, 2047 - 6);
      for (int k = 0; k < 3; k++) begin
        v[2*k]   = bx + $urandom_range(0, 6);
        v[2*k+1] = by + $urandom_range(0, 6);
      end
      run_tri(v, (i % 3 == 0) ? 1 : 2, $sformatf("rand%0d", i), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
